// File: rtl/cmd_queue_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_queue_sched_if
// Description : UART-side, cmd_proc-side and status signals of cmd_queue_sched.
//               The ovf signal exists only when CMDQ_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmd_queue_sched_if #(
    parameter int DEPTH = 4
);
    logic                     uart_rdy;
    logic [15:0]              uart_cmd;
    logic                     uart_clr;
    logic                     go;
    logic                     cmd_rdy;
    logic [15:0]              cmd;
    logic                     clr_cmd_rdy;
    logic                     flush;
    logic [$clog2(DEPTH):0]   q_cnt;
    logic                     q_full;
    logic                     q_empty;
`ifdef CMDQ_OVF_EN
    logic                     ovf;
`endif

    modport master (
        output uart_rdy, uart_cmd, go, clr_cmd_rdy, flush,
        input  uart_clr, cmd_rdy, cmd, q_cnt, q_full, q_empty
`ifdef CMDQ_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  uart_rdy, uart_cmd, go, clr_cmd_rdy, flush,
        output uart_clr, cmd_rdy, cmd, q_cnt, q_full, q_empty
`ifdef CMDQ_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/cmd_queue_sched.sv
`default_nettype none
// ============================================================================
// Module      : cmd_queue_sched
// Description : Command FIFO between UART_wrapper and cmd_proc; presents the
//               next command only after go has been low for GAP_CYC clocks.
//               Optional macro CMDQ_OVF_EN: drop words on full, sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_queue_sched #(
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cmd_queue_sched_if.slave    bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_GW = $clog2(GAP_CYC + 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYC - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GAP     = 2'd1;
    localparam logic [1:0] c_PRESENT = 2'd2;
    localparam logic [1:0] c_BUSY    = 2'd3;

    logic [15:0]      r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_hold;
    logic             r_uart_clr;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_GW-1:0]  r_gap_cnt;
    logic             w_cmd_rdy;

    logic w_full, w_empty, w_wr, w_drop, w_take, w_pop, w_gap_done;

    assign w_full  = (r_cnt == c_FULL_CNT);
    assign w_empty = (r_cnt == '0);
    assign w_wr    = bus.uart_rdy & ~w_full & ~r_hold & ~bus.flush;
    assign w_take  = w_wr | w_drop;
    assign w_pop   = (r_state == c_PRESENT) & bus.clr_cmd_rdy & ~w_empty & ~bus.flush;
    assign w_gap_done = (r_gap_cnt == c_GAP_LAST) & ~bus.go;

`ifdef CMDQ_OVF_EN
    logic r_ovf;

    // Full queue consumes and discards the word so the UART never stalls.
    assign w_drop = bus.uart_rdy & w_full & ~r_hold & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_ovf <= 1'b0;
        else if (w_drop)      r_ovf <= 1'b1;
    end

    assign bus.ovf = r_ovf;
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.uart_cmd;
    end

    // hold masks the cycle in which UART_wrapper is still dropping cmd_rdy.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_hold     <= 1'b0;
            r_uart_clr <= 1'b0;
        end else begin
            r_hold     <= w_take;
            r_uart_clr <= w_take;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_state <= c_IDLE;
        else                  r_state <= w_state_nxt;
    end

    // Counter saturates so a finished gap with an empty queue presents the
    // next arrival without another GAP_CYC wait.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_gap_cnt <= '0;
        end else if (r_state == c_GAP || r_state == c_BUSY) begin
            if (bus.go)                       r_gap_cnt <= '0;
            else if (r_gap_cnt != c_GAP_LAST) r_gap_cnt <= r_gap_cnt + 1'b1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (!w_empty)               w_state_nxt = c_GAP;
            c_GAP:     if (w_gap_done && !w_empty) w_state_nxt = c_PRESENT;
            c_PRESENT: if (w_pop)                  w_state_nxt = c_BUSY;
            c_BUSY:    if (bus.go || w_gap_done)   w_state_nxt = c_GAP;
            default:                               w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_rdy = 1'b0;
        if (r_state == c_PRESENT) w_cmd_rdy = 1'b1;
    end

    assign bus.cmd_rdy  = w_cmd_rdy;
    assign bus.cmd      = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign bus.uart_clr = r_uart_clr;
    assign bus.q_cnt    = r_cnt;
    assign bus.q_full   = w_full;
    assign bus.q_empty  = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_cmd_queue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_queue_sched
// Description : Scoreboard bench for cmd_queue_sched; queued words are checked
//               in order as cmd_proc captures them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_queue_sched;
    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_queue_sched_if #(.DEPTH(DEPTH)) bus ();

    cmd_queue_sched #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bit seen;
        seen = 1'b0;
        bus.uart_rdy = 1'b1;
        bus.uart_cmd = w;
        expq.push_back(w);
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (bus.uart_clr) seen = 1'b1;
        end
        bus.uart_rdy = 1'b0;
        check("uart_clr_seen", 32'(seen), 32'd1);
        tick();
        check("uart_clr_one_clk", 32'(bus.uart_clr), 32'd0);
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!bus.cmd_rdy && n < 200) begin
            tick();
            n++;
        end
        check("cmd_rdy_within_bound", 32'(bus.cmd_rdy), 32'd1);
    endtask

    task automatic handshake();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        check("cmd_rdy_drop", 32'(bus.cmd_rdy), 32'd0);
    endtask

    // Monitor: every capture by cmd_proc must deliver the oldest queued word.
    always @(negedge clk) begin
        if (!rst && bus.cmd_rdy && bus.clr_cmd_rdy) begin
            if (expq.size() == 0) begin
                check("dispatch_unexpected", 32'(bus.cmd), 32'hFFFF_FFFF);
            end else begin
                check("dispatch_order", 32'(bus.cmd), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int clr_cnt;
        bus.uart_rdy    = 1'b0;
        bus.uart_cmd    = 16'h0000;
        bus.go          = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.flush       = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();

        check("rst_q_cnt",    32'(bus.q_cnt),    32'd0);
        check("rst_q_empty",  32'(bus.q_empty),  32'd1);
        check("rst_q_full",   32'(bus.q_full),   32'd0);
        check("rst_cmd_rdy",  32'(bus.cmd_rdy),  32'd0);
        check("rst_cmd",      32'(bus.cmd),      32'd0);
        check("rst_uart_clr", 32'(bus.uart_clr), 32'd0);
`ifdef CMDQ_OVF_EN
        check("rst_ovf",      32'(bus.ovf),      32'd0);
`endif
        rst = 1'b0;
        tick();

        // Single command, go held low from reset.
        send(16'h00E7);
        check("one_q_cnt", 32'(bus.q_cnt), 32'd1);
        check("one_cmd",   32'(bus.cmd),   32'h00E7);
        wait_rdy(n);
        check("first_gap_len", 32'(n), 32'(GAP_CYC));
        handshake();
        check("one_popped_empty", 32'(bus.q_empty), 32'd1);

        // Fill the queue while go is high so nothing is dispatched yet.
        bus.go = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) send(16'(i));
        check("fill_q_cnt",  32'(bus.q_cnt),  32'd4);
        check("fill_q_full", 32'(bus.q_full), 32'd1);
        check("fill_head",   32'(bus.cmd),    32'h0001);

        bus.uart_rdy = 1'b1;
        bus.uart_cmd = 16'hBEEF;
        clr_cnt = 0;
        repeat (5) begin
            tick();
            if (bus.uart_clr) begin
                clr_cnt++;
                bus.uart_rdy = 1'b0;
            end
        end
        bus.uart_rdy = 1'b0;
`ifdef CMDQ_OVF_EN
        check("full_drop_clr", 32'(clr_cnt), 32'd1);
        check("full_ovf",      32'(bus.ovf), 32'd1);
`else
        check("full_backpressure_clr", 32'(clr_cnt), 32'd0);
`endif
        check("full_q_cnt", 32'(bus.q_cnt), 32'd4);

        bus.go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_rdy(n);
            handshake();
            bus.go = 1'b1;
            tick();
            tick();
            bus.go = 1'b0;
        end
        check("drain_empty", 32'(bus.q_empty), 32'd1);

        // go pulse at gap count 10 restarts the full gap.
        bus.go = 1'b1;
        tick();
        send(16'h0A5A);
        bus.go = 1'b0;
        repeat (10) tick();
        check("mid_gap_no_rdy", 32'(bus.cmd_rdy), 32'd0);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        wait_rdy(n);
        check("gap_restart_len", 32'(n), 32'(GAP_CYC));
        handshake();

        // Flush colliding with a capture and an incoming UART word.
        bus.go = 1'b1;
        tick();
        send(16'h0101);
        send(16'h0202);
        send(16'h0303);
        check("pre_flush_q_cnt", 32'(bus.q_cnt), 32'd3);
        bus.go = 1'b0;
        wait_rdy(n);
        bus.flush       = 1'b1;
        bus.clr_cmd_rdy = 1'b1;
        bus.uart_rdy    = 1'b1;
        bus.uart_cmd    = 16'h5555;
        tick();
        bus.flush       = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.uart_rdy    = 1'b0;
        expq.delete();
        check("flush_q_cnt",    32'(bus.q_cnt),    32'd0);
        check("flush_q_empty",  32'(bus.q_empty),  32'd1);
        check("flush_cmd_rdy",  32'(bus.cmd_rdy),  32'd0);
        check("flush_uart_clr", 32'(bus.uart_clr), 32'd0);
`ifdef CMDQ_OVF_EN
        check("flush_ovf",      32'(bus.ovf),      32'd0);
`endif
        tick();
        check("post_flush_q_cnt",    32'(bus.q_cnt),    32'd0);
        check("post_flush_uart_clr", 32'(bus.uart_clr), 32'd0);
        check("post_flush_cmd",      32'(bus.cmd),      32'd0);

        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
